ptr_cdc_sync_gen: RTL and testbench
===================================

Name: ptr_cdc_sync_gen

Overview:
- Generalised pointer synchroniser for the async FIFO; one instance serves either the read or the write domain.
- Carries a Gray-coded pointer from the opposite domain through a parametrised N-flop chain.
- Adds a registered Gray-to-binary conversion, a post-reset valid qualifier and a pointer-update pulse.
- Outputs feed the full/empty logic of the local domain.

Parameters:
- ADDRESS_WIDTH, 4: FIFO address bits; pointers are ADDRESS_WIDTH+1 bits wide.
- SYNC_STAGE, 2: number of synchroniser flops; legal values 2, 3, 4; any other value is an elaboration error.
- SOFT_RESET, 3: soft-reset honour mask; bit0 = read domain, bit1 = write domain.
- DOMAIN, 0: 0 = read-domain instance, 1 = write-domain instance. sw_rst is honoured only when SOFT_RESET bit[DOMAIN] = 1.

Ports:
- clk  in  1  local-domain clock
- hw_rst_n  in  1  asynchronous active-low hardware reset
- sw_rst  in  1  synchronous active-high soft reset, local domain
- din  in  ADDRESS_WIDTH+1  Gray pointer from the remote domain
- sync_gray  out  ADDRESS_WIDTH+1  synchronised Gray pointer
- sync_bin  out  ADDRESS_WIDTH+1  binary equivalent of sync_gray, registered
- sync_valid  out  1  high once the synchroniser chain has flushed after the last reset
- ptr_update  out  1  one-cycle pulse when sync_bin changes
- gray_err  out  1  sticky Gray-step violation flag

Behaviour:
- hw_rst_n low, asynchronous:
  - all chain flops, sync_gray, sync_bin and the prior-value register clear to all-zeros across the full ADDRESS_WIDTH+1 bits;
  - sync_valid, ptr_update and gray_err clear to 0; valid counter clears to 0.
- Effective sw_rst (sw_rst=1 and SOFT_RESET[DOMAIN]=1):
  - same clear as hw reset, applied synchronously at the next clk edge;
  - takes priority over normal shifting.
  - If the SOFT_RESET bit is 0, sw_rst is ignored completely.
- Chain:
  - stage[0] <= din; stage[k] <= stage[k-1];
  - sync_gray = stage[SYNC_STAGE-1];
  - latency din -> sync_gray = SYNC_STAGE clk edges.
- Conversion: sync_bin <= gray2bin(sync_gray), so latency din -> sync_bin = SYNC_STAGE+1 edges. Conversion is an XOR prefix from the MSB: bin[MSB]=g[MSB], bin[i]=bin[i+1]^g[i].
- Valid counter:
  - counts from 0 after any reset and saturates at SYNC_STAGE+1;
  - sync_valid = 1 when count == SYNC_STAGE+1, i.e. the output is asserted the cycle after the counter saturates (registered);
  - it then stays high until the next reset.
- ptr_update:
  - asserts 1 cycle after sync_bin differs from its previous registered value;
  - suppressed while sync_valid = 0.
- gray_err:
  - set when sync_valid = 1 and the Hamming distance between consecutive sync_gray values exceeds 1;
  - sticky; cleared only by a reset.
- Wrap-around: a Gray transition from 1000..0 to 0000..0 is a single-bit step and is legal; sync_bin wraps from 2^(ADDRESS_WIDTH+1)-1 to 0 without error.
- Reset mid-stream:
  - in-flight chain contents are discarded;
  - sync_valid drops in the same cycle the reset is applied;
  - ptr_update cannot fire for the reset-induced change to zero.

Optional Feature:
- Macro PTR_SYNC_ERRCNT_EN.
- Defined:
  - adds output err_cnt [7:0], a saturating count of Gray-step violations;
  - cleared by both hw and soft reset;
  - increments in the same cycle gray_err would set.
- Undefined: no err_cnt port or counter; only the sticky gray_err flag exists.

Decomposition:
- Package async_fifo_pkg holds:
  - gray2bin and bin2gray functions;
  - SOFT_RESET bit constants (SR_RD_BIT=0, SR_WR_BIT=1);
  - DOMAIN constants (DOM_RD=0, DOM_WR=1);
  - a popcount helper for the Hamming check.
- One sub-module is natural: gray_step_checker, which holds the prior-value register, the Hamming compare, gray_err and the optional err_cnt.

Test Plan:
- ADDRESS_WIDTH=4, SYNC_STAGE=3: drive din=5'b00001 at cycle 10 -> sync_gray=5'b00001 at cycle 13, sync_bin=5'b00001 at cycle 14, ptr_update pulses at cycle 15.
- Release hw_rst_n at cycle 0 with SYNC_STAGE=2 -> sync_valid low for cycles 0-2, high from cycle 4; gray_err stays 0.
- DOMAIN=0, SOFT_RESET=2, sw_rst=1 with sync_bin=7 -> no clear, sync_bin stays 7. Repeat with SOFT_RESET=1 -> all outputs 0 one edge later, sync_valid low.
- Walk a Gray counter through 32 values including the wrap 5'b10000 -> 5'b00000 -> sync_bin sequence 0..31,0, gray_err=0.
- Jump din 5'b00000 -> 5'b00011 after sync_valid -> gray_err=1 SYNC_STAGE+1 edges later and sticky. With PTR_SYNC_ERRCNT_EN, err_cnt=1; 300 further violations give err_cnt=255.
- Assert hw_rst_n low mid-stream at sync_bin=12 -> all outputs 0 immediately (asynchronous); no ptr_update pulse after release.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray/binary conversion, popcount,
// and the soft-reset mask and domain constants.
package async_fifo_pkg;

  localparam int SR_RD_BIT = 0;
  localparam int SR_WR_BIT = 1;
  localparam int DOM_RD    = 0;
  localparam int DOM_WR    = 1;

  // Zero-extended inputs leave the MSB-first XOR prefix unchanged in the low bits.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      c += {31'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ptr_cdc_sync_gen_gray_step_checker.sv
// gray_step_checker: flags consecutive synchronised Gray values differing in more than one bit.
// Latency: gray_err/err_cnt update one edge after the offending sample.
// No backpressure; err_cnt exists only with PTR_SYNC_ERRCNT_EN.
module gray_step_checker
  import async_fifo_pkg::*;
#(
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             hw_rst_n,
  input  logic             clr,
  input  logic             check_en,
  input  logic [PTR_W-1:0] gray,
  output logic             gray_err
`ifdef PTR_SYNC_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  logic [PTR_W-1:0] prev_gray;
  logic             step_bad;

  assign step_bad = check_en && (popcount(32'(gray ^ prev_gray)) > 32'd1);

  always_ff @(posedge clk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      prev_gray <= '0;
      gray_err  <= 1'b0;
    end else if (clr) begin
      prev_gray <= '0;
      gray_err  <= 1'b0;
    end else begin
      prev_gray <= gray;
      if (step_bad) gray_err <= 1'b1;
    end
  end

`ifdef PTR_SYNC_ERRCNT_EN
  always_ff @(posedge clk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      err_cnt <= 8'd0;
    end else if (clr) begin
      err_cnt <= 8'd0;
    end else if (step_bad && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: rtl/ptr_cdc_sync_gen.sv
// ptr_cdc_sync_gen: remote Gray pointer synchroniser with registered binary, valid qualifier and update pulse.
// Latency: din->sync_gray SYNC_STAGE edges, din->sync_bin SYNC_STAGE+1, ptr_update one edge after sync_bin.
// No backpressure; PTR_SYNC_ERRCNT_EN adds the saturating err_cnt output.
module ptr_cdc_sync_gen
  import async_fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int SYNC_STAGE    = 2,
  parameter int SOFT_RESET    = 3,
  parameter int DOMAIN        = 0
) (
  input  logic                   clk,
  input  logic                   hw_rst_n,
  input  logic                   sw_rst,
  input  logic [ADDRESS_WIDTH:0] din,
  output logic [ADDRESS_WIDTH:0] sync_gray,
  output logic [ADDRESS_WIDTH:0] sync_bin,
  output logic                   sync_valid,
  output logic                   ptr_update,
  output logic                   gray_err
`ifdef PTR_SYNC_ERRCNT_EN
  ,
  output logic [7:0]             err_cnt
`endif
);

  localparam int         PTR_W   = ADDRESS_WIDTH + 1;
  localparam bit         SR_EN   = (DOMAIN == DOM_WR) ? (((SOFT_RESET >> SR_WR_BIT) & 1) != 0)
                                                      : (((SOFT_RESET >> SR_RD_BIT) & 1) != 0);
  localparam logic [2:0] CNT_MAX = 3'(SYNC_STAGE + 1);

  if (SYNC_STAGE < 2 || SYNC_STAGE > 4) begin : g_bad_sync_stage
    $error("ptr_cdc_sync_gen: SYNC_STAGE must be 2, 3 or 4");
  end
  if (DOMAIN != DOM_RD && DOMAIN != DOM_WR) begin : g_bad_domain
    $error("ptr_cdc_sync_gen: DOMAIN must be 0 or 1");
  end

  logic             clr;
  logic [PTR_W-1:0] stage [SYNC_STAGE];
  logic [PTR_W-1:0] prev_bin;
  logic [2:0]       vcnt;

  assign clr       = sw_rst & SR_EN;
  assign sync_gray = stage[SYNC_STAGE-1];

  always_ff @(posedge clk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      for (int k = 0; k < SYNC_STAGE; k++) stage[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < SYNC_STAGE; k++) stage[k] <= '0;
    end else begin
      stage[0] <= din;
      for (int k = 1; k < SYNC_STAGE; k++) stage[k] <= stage[k-1];
    end
  end

  // prev_bin clears with sync_bin, so a reset never looks like a pointer move.
  always_ff @(posedge clk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      vcnt       <= 3'd0;
      sync_valid <= 1'b0;
      sync_bin   <= '0;
      prev_bin   <= '0;
      ptr_update <= 1'b0;
    end else if (clr) begin
      vcnt       <= 3'd0;
      sync_valid <= 1'b0;
      sync_bin   <= '0;
      prev_bin   <= '0;
      ptr_update <= 1'b0;
    end else begin
      if (vcnt != CNT_MAX) vcnt <= vcnt + 3'd1;
      sync_valid <= (vcnt == CNT_MAX);
      sync_bin   <= PTR_W'(gray2bin(32'(sync_gray)));
      prev_bin   <= sync_bin;
      ptr_update <= sync_valid && (sync_bin != prev_bin);
    end
  end

  gray_step_checker #(
    .PTR_W(PTR_W)
  ) u_chk (
    .clk      (clk),
    .hw_rst_n (hw_rst_n),
    .clr      (clr),
    .check_en (sync_valid),
    .gray     (sync_gray),
    .gray_err (gray_err)
`ifdef PTR_SYNC_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

endmodule

// File: tb/tb_ptr_cdc_sync_gen.sv
// Bench: three instances (S=3 honouring sw_rst, S=2 ignoring it, S=4 write-domain honouring it)
// against a cycle-history reference model plus literal spot checks.
module tb_ptr_cdc_sync_gen;

  localparam int NI   = 3;
  localparam int MAXC = 4096;

  logic            clk = 1'b0;
  logic            hw_rst_n;
  logic            sw_rst;
  logic [4:0]      din;
  logic [2:0][4:0] o_gray;
  logic [2:0][4:0] o_bin;
  logic [2:0]      o_valid;
  logic [2:0]      o_upd;
  logic [2:0]      o_err;
`ifdef PTR_SYNC_ERRCNT_EN
  logic [2:0][7:0] o_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ptr_cdc_sync_gen #(.ADDRESS_WIDTH(4), .SYNC_STAGE(3), .SOFT_RESET(1), .DOMAIN(0)) u_dut0 (
    .clk(clk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .din(din),
    .sync_gray(o_gray[0]), .sync_bin(o_bin[0]), .sync_valid(o_valid[0]),
    .ptr_update(o_upd[0]), .gray_err(o_err[0])
`ifdef PTR_SYNC_ERRCNT_EN
    , .err_cnt(o_cnt[0])
`endif
  );

  ptr_cdc_sync_gen #(.ADDRESS_WIDTH(4), .SYNC_STAGE(2), .SOFT_RESET(2), .DOMAIN(0)) u_dut1 (
    .clk(clk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .din(din),
    .sync_gray(o_gray[1]), .sync_bin(o_bin[1]), .sync_valid(o_valid[1]),
    .ptr_update(o_upd[1]), .gray_err(o_err[1])
`ifdef PTR_SYNC_ERRCNT_EN
    , .err_cnt(o_cnt[1])
`endif
  );

  ptr_cdc_sync_gen #(.ADDRESS_WIDTH(4), .SYNC_STAGE(4), .SOFT_RESET(2), .DOMAIN(1)) u_dut2 (
    .clk(clk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .din(din),
    .sync_gray(o_gray[2]), .sync_bin(o_bin[2]), .sync_valid(o_valid[2]),
    .ptr_update(o_upd[2]), .gray_err(o_err[2])
`ifdef PTR_SYNC_ERRCNT_EN
    , .err_cnt(o_cnt[2])
`endif
  );

  // Expected outputs per instance, indexed by clock edge number.
  logic [4:0] din_h [MAXC];
  logic [4:0] eg [NI][MAXC];
  logic [4:0] eb [NI][MAXC];
  logic       ev [NI][MAXC];
  logic       eu [NI][MAXC];
  logic       ee [NI][MAXC];
  logic [7:0] ec [NI][MAXC];
  int         kk [NI];
  int         n;

  function automatic int s_of(input int i);
    return (i == 0) ? 3 : (i == 1) ? 2 : 4;
  endfunction

  function automatic bit hon_of(input int i);
    return (i != 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] g);
    for (int v = 0; v < 32; v++) begin
      if (5'(v ^ (v >> 1)) == g) return 5'(v);
    end
    return 5'd0;
  endfunction

  task automatic zero_entry(input int i, input int idx);
    eg[i][idx] = '0; eb[i][idx] = '0; ev[i][idx] = 1'b0;
    eu[i][idx] = 1'b0; ee[i][idx] = 1'b0; ec[i][idx] = 8'd0;
  endtask

  task automatic model_edge();
    int  s;
    bit  bad;
    n++;
    if (n >= MAXC) begin
      errors++;
      $display("FAIL model_overflow cycle %0d limit %0d", n, MAXC);
      $fatal(1, "model history exhausted");
    end
    din_h[n] = din;
    for (int i = 0; i < NI; i++) begin
      if (!hw_rst_n || (sw_rst && hon_of(i))) begin
        kk[i] = 0;
        zero_entry(i, n);
      end else begin
        kk[i]++;
        s = s_of(i);
        eg[i][n] = (kk[i] >= s) ? din_h[n-s+1] : 5'd0;
        eb[i][n] = g2b(eg[i][n-1]);
        ev[i][n] = (kk[i] >= s + 2);
        eu[i][n] = ev[i][n-1] && (eb[i][n-1] != eb[i][n-2]);
        bad      = ev[i][n-1] && ($countones(eg[i][n-1] ^ eg[i][n-2]) > 1);
        ee[i][n] = ee[i][n-1] || bad;
        ec[i][n] = (bad && ec[i][n-1] != 8'hFF) ? ec[i][n-1] + 8'd1 : ec[i][n-1];
      end
    end
  endtask

  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d got %0h expected %0h", nm, inst, n, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check("sync_gray",  i, 32'(o_gray[i]),  32'(eg[i][n]));
      check("sync_bin",   i, 32'(o_bin[i]),   32'(eb[i][n]));
      check("sync_valid", i, 32'(o_valid[i]), 32'(ev[i][n]));
      check("ptr_update", i, 32'(o_upd[i]),   32'(eu[i][n]));
      check("gray_err",   i, 32'(o_err[i]),   32'(ee[i][n]));
`ifdef PTR_SYNC_ERRCNT_EN
      check("err_cnt",    i, 32'(o_cnt[i]),   32'(ec[i][n]));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic steps(input int cnt);
    for (int j = 0; j < cnt; j++) step();
  endtask

  task automatic drive_bin(input logic [4:0] v);
    din = v ^ (v >> 1);
  endtask

  // Called just after a compare, well away from the rising edge.
  task automatic hw_reset_async();
    hw_rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      kk[i] = 0;
      zero_entry(i, n);
    end
    compare_all();
  endtask

  logic [4:0] seen [$];
  logic [4:0] v;
  int         r;

  initial begin
    hw_rst_n = 1'b0;
    sw_rst   = 1'b0;
    din      = 5'd0;
    n        = 1;
    for (int i = 0; i < NI; i++) begin
      kk[i] = 0;
      zero_entry(i, 0);
      zero_entry(i, 1);
    end
    steps(3);
    check("reset_bin_lit", 0, 32'(o_bin[0]), 32'd0);

    // Release; S=2 instance: valid low through cycle 3, high at cycle 4.
    hw_rst_n = 1'b1;
    step(); check("valid_c1_lit", 1, 32'(o_valid[1]), 32'd0);
    step(); check("valid_c2_lit", 1, 32'(o_valid[1]), 32'd0);
    step(); check("valid_c3_lit", 1, 32'(o_valid[1]), 32'd0);
    step(); check("valid_c4_lit", 1, 32'(o_valid[1]), 32'd1);
    check("err_idle_lit", 1, 32'(o_err[1]), 32'd0);
    steps(6);

    // Single pointer move through the S=3 instance.
    din = 5'b00001;
    steps(2); check("gray_c2_lit", 0, 32'(o_gray[0]), 32'd0);
    step();   check("gray_c3_lit", 0, 32'(o_gray[0]), 32'd1);
    step();   check("bin_c4_lit",  0, 32'(o_bin[0]),  32'd1);
    check("upd_c4_lit", 0, 32'(o_upd[0]), 32'd0);
    step();   check("upd_c5_lit",  0, 32'(o_upd[0]),  32'd1);
    step();   check("upd_c6_lit",  0, 32'(o_upd[0]),  32'd0);

    // Bring pointer to 7, then soft reset.
    for (int b = 2; b <= 7; b++) begin
      drive_bin(5'(b));
      step();
    end
    steps(6);
    check("bin7_lit", 1, 32'(o_bin[1]), 32'd7);
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    check("swign_bin_lit",   1, 32'(o_bin[1]),   32'd7);
    check("swign_valid_lit", 1, 32'(o_valid[1]), 32'd1);
    check("sw_bin_lit",      0, 32'(o_bin[0]),   32'd0);
    check("sw_gray_lit",     0, 32'(o_gray[0]),  32'd0);
    check("sw_valid_lit",    0, 32'(o_valid[0]), 32'd0);
    check("sw_wr_bin_lit",   2, 32'(o_bin[2]),   32'd0);
    steps(8);

    // Walk through the wrap 10000 -> 00000.
    seen.delete();
    seen.push_back(o_bin[0]);
    for (int b = 8; b <= 32; b++) begin
      drive_bin(5'(b % 32));
      step();
      if (o_bin[0] != seen[$]) seen.push_back(o_bin[0]);
    end
    for (int j = 0; j < 6; j++) begin
      step();
      if (o_bin[0] != seen[$]) seen.push_back(o_bin[0]);
    end
    check("walk_len", 0, 32'(seen.size()), 32'd26);
    for (int j = 0; j < seen.size() && j < 26; j++) begin
      check("walk_seq", 0, 32'(seen[j]), 32'((j + 7) % 32));
    end
    check("walk_err_lit", 0, 32'(o_err[0]), 32'd0);

    // Two-bit jump, then a long run of violations.
    din = 5'b00011;
    steps(3); check("jump_c3_lit", 0, 32'(o_err[0]), 32'd0);
    step();   check("jump_c4_lit", 0, 32'(o_err[0]), 32'd1);
    steps(3); check("jump_sticky_lit", 0, 32'(o_err[0]), 32'd1);
`ifdef PTR_SYNC_ERRCNT_EN
    check("errcnt_one_lit", 0, 32'(o_cnt[0]), 32'd1);
`endif
    for (int j = 0; j < 300; j++) begin
      din = (din == 5'b00011) ? 5'b00000 : 5'b00011;
      step();
    end
    steps(5);
    check("jump_run_err_lit", 0, 32'(o_err[0]), 32'd1);
`ifdef PTR_SYNC_ERRCNT_EN
    check("errcnt_sat_lit", 0, 32'(o_cnt[0]), 32'd255);
`endif

    // Async hardware reset mid-stream at pointer 12.
    drive_bin(5'd12);
    steps(6);
    check("bin12_lit", 0, 32'(o_bin[0]), 32'd12);
    hw_reset_async();
    check("hw_bin_lit",   0, 32'(o_bin[0]),   32'd0);
    check("hw_gray_lit",  0, 32'(o_gray[0]),  32'd0);
    check("hw_valid_lit", 0, 32'(o_valid[0]), 32'd0);
    check("hw_err_lit",   0, 32'(o_err[0]),   32'd0);
    steps(2);
    hw_rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      check("hw_noupd_lit", 0, 32'(o_upd[0]), 32'd0);
    end
    check("hw_recover_bin_lit", 0, 32'(o_bin[0]), 32'd12);

    // Randomised traffic against the model.
    v = 5'd12;
    for (int j = 0; j < 1500; j++) begin
      r = int'($urandom_range(0, 199));
      if (r < 100)      v = v + 5'd1;
      else if (r < 120) v = v - 5'd1;
      else if (r < 124) v = 5'($urandom_range(0, 31));
      drive_bin(v);
      sw_rst = (r == 124 || r == 125);
      if (r == 126) begin
        hw_reset_async();
        steps(2);
        hw_rst_n = 1'b1;
      end
      step();
    end
    sw_rst = 1'b0;
    steps(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
